rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_pkg.sv | 8 +
 rtl/rr_mux_arbiter_mux8x1.sv | 8 +
 rtl/rr_mux_arbiter.sv | 107 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and state type for the round-robin grant/mux slice.
package rr_mux_pkg;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_mux_arbiter_mux8x1.sv
// Team 8:1 single-bit multiplexer.
module mux8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);
  assign y = i[s];
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over 8 requesters with bounded hold time; routes the
// granted requester's data bit to y while a grant is active.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] i,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       busy,
  output logic       y
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               mux_y;

  // First set bit of r at or above start, wrapping 7->0.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    win   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = start + SEL_W'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (|req) begin
          state_d          = GRANT;
          s_d              = rr_pick(req, ptr_q);
          gnt_d[s_d]       = 1'b1;
          busy_d           = 1'b1;
          cnt_d            = '0;
        end
      end
      GRANT: begin
        // Requester drop and hold expiry on the same edge collapse into one release.
        if (!req[s_q] || cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = s_q + SEL_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  mux8x1 u_mux (
    .i (i),
    .s (s_q),
    .y (mux_y)
  );

  assign gnt  = gnt_q;
  assign s    = s_q;
  assign busy = busy_q;
  assign y    = busy_q & mux_y;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: hold limit, rotation, early release,
// wrap search, async reset and coincident release on a MAX_HOLD=1 instance.
module tb_rr_mux_arbiter;
  logic       clk;
  logic       rst;
  logic [7:0] req, req1, i;
  logic [7:0] gnt, gnt1;
  logic [2:0] s, s1;
  logic       busy, busy1, y, y1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rr_mux_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk), .rst (rst), .req (req), .i (i),
    .gnt (gnt), .s (s), .busy (busy), .y (y)
  );

  rr_mux_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk (clk), .rst (rst), .req (req1), .i (i),
    .gnt (gnt1), .s (s1), .busy (busy1), .y (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ends on a negedge with rst just released and all requests low.
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    req1 = '0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] eg;
    rst  = 1'b1;
    req  = '0;
    req1 = '0;
    i    = 8'hFF;

    // Single requester 2: 4 grant cycles then 1 idle, y follows i[2] only while busy.
    do_reset();
    i   = 8'h04;
    req = 8'h04;
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h04);
        chk("single_s", 32'(s), 32'h2);
        chk("single_busy", 32'(busy), 32'h1);
        i = 8'h04; #1;
        chk("single_y1", 32'(y), 32'h1);
        i = 8'hFB; #1;
        chk("single_y0", 32'(y), 32'h0);
      end
      @(negedge clk);
      i = 8'hFF; #1;
      chk("single_gap_gnt", 32'(gnt), 32'h00);
      chk("single_gap_busy", 32'(busy), 32'h0);
      chk("single_gap_s", 32'(s), 32'h2);
      chk("single_gap_y", 32'(y), 32'h0);
    end

    // Full contention rotation 0..7,0.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      eg = 8'h01 << (g % 8);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("rot_gnt", 32'(gnt), 32'(eg));
        chk("rot_s", 32'(s), 32'(g % 8));
        chk("rot_busy", 32'(busy), 32'h1);
      end
      @(negedge clk);
      chk("rot_gap_busy", 32'(busy), 32'h0);
      chk("rot_gap_gnt", 32'(gnt), 32'h00);
      chk("rot_gap_s", 32'(s), 32'(g % 8));
    end

    // Early release of 0, then 7, then search restarts at 0.
    do_reset();
    req = 8'h81;
    @(negedge clk);
    chk("early_g0_c1", 32'(gnt), 32'h01);
    @(negedge clk);
    chk("early_g0_c2", 32'(gnt), 32'h01);
    req = 8'h80;
    @(negedge clk);
    chk("early_gap_busy", 32'(busy), 32'h0);
    chk("early_gap_s", 32'(s), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("early_g7_gnt", 32'(gnt), 32'h80);
      chk("early_g7_s", 32'(s), 32'h7);
    end
    @(negedge clk);
    chk("early_gap2_busy", 32'(busy), 32'h0);
    req = 8'h81;
    @(negedge clk);
    chk("early_after7_s", 32'(s), 32'h0);
    chk("early_after7_gnt", 32'(gnt), 32'h01);

    // Wrap search from ptr=6, then ptr=2 picks 5.
    do_reset();
    req = 8'h20;
    @(negedge clk);
    chk("wrap_pre_s", 32'(s), 32'h5);
    req = 8'h00;
    @(negedge clk);
    chk("wrap_pre_gap", 32'(busy), 32'h0);
    req = 8'h22;
    @(negedge clk);
    chk("wrap_s", 32'(s), 32'h1);
    chk("wrap_gnt", 32'(gnt), 32'h02);
    req = 8'h20;
    @(negedge clk);
    chk("wrap_gap", 32'(busy), 32'h0);
    req = 8'h22;
    @(negedge clk);
    chk("wrap_next_s", 32'(s), 32'h5);
    chk("wrap_next_gnt", 32'(gnt), 32'h20);

    // Async reset during cycle 2 of grant to 5.
    i = 8'hFF;
    @(negedge clk);
    chk("rstmid_pre_busy", 32'(busy), 32'h1);
    chk("rstmid_pre_y", 32'(y), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_gnt", 32'(gnt), 32'h00);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_s", 32'(s), 32'h0);
    chk("rstmid_y", 32'(y), 32'h0);
    req = 8'hFF;
    @(negedge clk);
    chk("rstmid_hold_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_first_s", 32'(s), 32'h0);
    chk("rstmid_first_gnt", 32'(gnt), 32'h01);

    // MAX_HOLD=1: req[3] falls on the expiry edge -> single release, ptr=4.
    do_reset();
    req1 = 8'h08;
    @(negedge clk);
    chk("mh1_s", 32'(s1), 32'h3);
    chk("mh1_busy", 32'(busy1), 32'h1);
    req1 = 8'h00;
    @(negedge clk);
    chk("mh1_gap_busy", 32'(busy1), 32'h0);
    chk("mh1_gap_gnt", 32'(gnt1), 32'h00);
    req1 = 8'h18;
    @(negedge clk);
    chk("mh1_next_s", 32'(s1), 32'h4);
    chk("mh1_next_gnt", 32'(gnt1), 32'h10);
    @(negedge clk);
    chk("mh1_gap2_busy", 32'(busy1), 32'h0);
    @(negedge clk);
    chk("mh1_wrap_s", 32'(s1), 32'h3);
    chk("mh1_wrap_gnt", 32'(gnt1), 32'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
